asi: RTL and testbench

ASI -- requirements
Module: asi

---
 rtl/asi.sv | 128 ++++++++++++
 tb/tb_asi.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/asi.sv
// ASI single-cycle core: 256x32 register file, pc/ra/dummyReg, combinational operand and write-back paths.
// All state commits on the rising clock edge when write_enable=1; asynchronous active-low reset.
module asi (
   input  logic        clock,
   input  logic        reset,
   input  logic        write_enable,
   input  logic [31:0] instruction,
   output logic [31:0] data1,
   output logic [31:0] data2,
   output logic [31:0] dataRD,
   output logic [31:0] pc,
   output logic [31:0] ra,
   output logic [31:0] dummyReg
);

   localparam logic [7:0] OP_JUMP  = 8'h01;
   localparam logic [7:0] OP_JAL   = 8'h02;
   localparam logic [7:0] OP_AND   = 8'h05;
   localparam logic [7:0] OP_OR    = 8'h06;
   localparam logic [7:0] OP_XOR   = 8'h07;
   localparam logic [7:0] OP_ADD   = 8'h08;
   localparam logic [7:0] OP_SUB   = 8'h09;
   localparam logic [7:0] OP_MUL   = 8'h0A;
   localparam logic [7:0] OP_BEQR  = 8'h41;
   localparam logic [7:0] OP_BNER  = 8'h42;
   localparam logic [7:0] OP_BEQI  = 8'h43;
   localparam logic [7:0] OP_BNEI  = 8'h44;
   localparam logic [7:0] OP_ANDI  = 8'h45;
   localparam logic [7:0] OP_ORI   = 8'h46;
   localparam logic [7:0] OP_XORI  = 8'h47;
   localparam logic [7:0] OP_SLLI  = 8'h48;
   localparam logic [7:0] OP_SRLI  = 8'h49;
   localparam logic [7:0] OP_ADDI  = 8'h4A;
   localparam logic [7:0] OP_SUBI  = 8'h4B;
   localparam logic [7:0] OP_MPLI  = 8'h4C;
   localparam logic [7:0] OP_LOADI = 8'h81;
   localparam logic [7:0] OP_LOADR = 8'h82;
   localparam logic [7:0] OP_STORE = 8'h83;

   logic [31:0] regs [256];
   logic [7:0]  op, fa, fb, fc;
   logic [31:0] imm;
   logic [23:0] tgt;
   logic        wr;
   logic [31:0] pc_inc, pc_nxt;

   assign op  = instruction[31:24];
   assign fa  = instruction[23:16];
   assign fb  = instruction[15:8];
   assign fc  = instruction[7:0];
   assign imm = {16'h0000, instruction[15:0]};
   assign tgt = instruction[23:0];

   // Operand routing: R-type and shifts read (C,B), register branches read (A,B), everything else (B,A).
   always_comb begin
      data1 = regs[fb];
      data2 = regs[fa];
      case (op)
         OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_SLLI, OP_SRLI: begin
            data1 = regs[fc];
            data2 = regs[fb];
         end
         OP_BEQR, OP_BNER: begin
            data1 = regs[fa];
            data2 = regs[fb];
         end
         default: ;
      endcase
   end

   always_comb begin
      wr     = 1'b1;
      dataRD = '0;
      case (op)
         OP_AND:   dataRD = data2 & data1;
         OP_OR:    dataRD = data2 | data1;
         OP_XOR:   dataRD = data2 ^ data1;
         OP_ADD:   dataRD = data2 + data1;
         OP_SUB:   dataRD = data2 - data1;
         OP_MUL:   dataRD = data2 * data1;
         OP_ANDI:  dataRD = data2 & imm;
         OP_ORI:   dataRD = data2 | imm;
         OP_XORI:  dataRD = data2 ^ imm;
         OP_ADDI:  dataRD = data2 + imm;
         OP_SUBI:  dataRD = data2 - imm;
         OP_MPLI:  dataRD = data2 * imm;
         OP_SLLI:  dataRD = (fc >= 8'd32) ? '0 : (data2 << fc[4:0]);
         OP_SRLI:  dataRD = (fc >= 8'd32) ? '0 : (data2 >> fc[4:0]);
         OP_LOADI: dataRD = imm;
         OP_LOADR: dataRD = dummyReg;
         default:  wr = 1'b0;
      endcase
   end

   always_comb begin
      pc_inc = pc + 32'd1;
      pc_nxt = pc_inc;
      case (op)
         OP_BEQR: if (data1 == data2) pc_nxt = pc + {24'h000000, fc};
         OP_BNER: if (data1 != data2) pc_nxt = pc + {24'h000000, fc};
         OP_BEQI: if (data2 == imm)   pc_nxt = pc + 32'd2;
         OP_BNEI: if (data2 != imm)   pc_nxt = pc + 32'd2;
         OP_JUMP, OP_JAL: pc_nxt = {8'h00, tgt};
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 256; k++) regs[k] <= 32'(k);
      end else if (write_enable && wr) begin
         regs[fa] <= dataRD;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc       <= '0;
         ra       <= '0;
         dummyReg <= '0;
      end else if (write_enable) begin
         pc <= pc_nxt;
         if (op == OP_JAL)   ra       <= pc_inc;
         if (op == OP_STORE) dummyReg <= data2;
      end
   end

endmodule

// File: tb/tb_asi.sv
// Directed self-checking bench for asi; register contents are observed through the data2 operand path.
module tb_asi;

   logic        clock;
   logic        reset;
   logic        write_enable;
   logic [31:0] instruction;
   logic [31:0] data1, data2, dataRD, pc, ra, dummyReg;

   int total = 0;
   int bad   = 0;

   asi dut (
      .clock        (clock),
      .reset        (reset),
      .write_enable (write_enable),
      .instruction  (instruction),
      .data1        (data1),
      .data2        (data2),
      .dataRD       (dataRD),
      .pc           (pc),
      .ra           (ra),
      .dummyReg     (dummyReg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Commit one instruction: drive at falling edge, sample 1ns after the rising edge.
   task automatic exec(input logic [31:0] ins);
      @(negedge clock);
      instruction  = ins;
      write_enable = 1'b1;
      @(posedge clock);
      #1;
      write_enable = 1'b0;
   endtask

   // Opcode 0x00 is a NOP whose data2 operand is R[A].
   task automatic peek(input logic [7:0] idx, output logic [31:0] val);
      write_enable = 1'b0;
      instruction  = {8'h00, idx, 16'h0000};
      #1;
      val = data2;
   endtask

   task automatic check_reg(input string tag, input logic [7:0] idx, input logic [31:0] exp);
      logic [31:0] v;
      peek(idx, v);
      check(tag, v, exp);
   endtask

   initial begin
      logic [31:0] pc_hold;
      reset        = 1'b0;
      write_enable = 1'b0;
      instruction  = '0;
      #12;
      check("rst_pc", pc, 32'd0);
      check("rst_ra", ra, 32'd0);
      check("rst_dmy", dummyReg, 32'd0);
      check_reg("rst_r0", 8'd0, 32'd0);
      check_reg("rst_r5", 8'd5, 32'd5);
      check_reg("rst_r255", 8'd255, 32'd255);

      @(negedge clock);
      reset = 1'b1;

      // ANDR: pre-edge combinational view, then commit
      @(negedge clock);
      instruction  = 32'h05030201;
      write_enable = 1'b1;
      #1;
      check("andr_d1", data1, 32'd1);
      check("andr_d2", data2, 32'd2);
      check("andr_rd", dataRD, 32'd0);
      @(posedge clock);
      #1;
      write_enable = 1'b0;
      check("andr_pc", pc, 32'd1);
      check_reg("andr_r3", 8'd3, 32'd0);

      exec(32'h080C0B0A);
      check_reg("addr_r12", 8'd12, 32'd21);
      check("addr_pc", pc, 32'd2);

      exec(32'h4A160064);
      check_reg("addi_r22", 8'd22, 32'd122);
      exec(32'h4B170064);
      check_reg("subi_r23", 8'd23, 32'hFFFFFFB3);
      exec(32'h4C180064);
      check_reg("mpli_r24", 8'd24, 32'd2400);
      exec(32'h481A190A);
      check_reg("slli_r26", 8'd26, 32'd25600);
      exec(32'h491C1B0A);
      check_reg("srli_r28", 8'd28, 32'd0);
      exec(32'h481F0120);
      check_reg("slli32_r31", 8'd31, 32'd0);
      exec(32'h090D0E0F);
      check_reg("subr_r13", 8'd13, 32'hFFFFFFFF);
      check("shift_pc", pc, 32'd9);

      exec(32'h411D1E0A);
      check("beqr_ne_pc", pc, 32'd10);
      exec(32'h4105050A);
      check("beqr_eq_pc", pc, 32'd20);
      exec(32'h44250000);
      check("bnei_pc", pc, 32'd22);
      exec(32'h43250025);
      check("beqi_pc", pc, 32'd24);

      exec(32'h02F0F0F0);
      check("jal_ra", ra, 32'd25);
      check("jal_pc", pc, 32'h00F0F0F0);
      exec(32'h83640000);
      check("store_dmy", dummyReg, 32'd100);
      exec(32'h820C0000);
      check_reg("loadr_r12", 8'd12, 32'd100);
      exec(32'h8105BEEF);
      check_reg("loadi_r5", 8'd5, 32'h0000BEEF);
      exec(32'hFF000000);
      check("undef_pc", pc, 32'h00F0F0F4);

      // write_enable low: state frozen, combinational outputs still follow instruction
      @(negedge clock);
      instruction  = 32'h4A160064;
      write_enable = 1'b0;
      pc_hold      = pc;
      repeat (5) @(posedge clock);
      #1;
      check("hold_rd", dataRD, 32'd222);
      check("hold_pc", pc, pc_hold);
      check_reg("hold_r22", 8'd22, 32'd122);

      // asynchronous reset mid-cycle, held across a committing edge
      @(negedge clock);
      instruction  = 32'h02F0F0F0;
      write_enable = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check("arst_pc", pc, 32'd0);
      check("arst_ra", ra, 32'd0);
      check("arst_dmy", dummyReg, 32'd0);
      write_enable = 1'b1;
      instruction  = 32'h02F0F0F0;
      @(posedge clock);
      #1;
      check("arst_hold_pc", pc, 32'd0);
      check_reg("arst_r12", 8'd12, 32'd12);
      check_reg("arst_r22", 8'd22, 32'd22);
      @(negedge clock);
      reset = 1'b1;
      exec(32'h080C0B0A);
      check_reg("post_r12", 8'd12, 32'd21);
      check("post_pc", pc, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
